// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage: RV32I instruction decode pipeline stage (IF -> ID -> EX).
//
// Accepts {instr, pc} from IF over a give/get handshake into a one-entry hold
// register, decodes the RV32I fields and immediates, reads two register-file
// operands combinationally and hands a registered decode bundle to EX over a
// second give/get handshake. A 32-entry pending-write scoreboard stalls the
// held instruction while any register it reads has an uncommitted writer.
//
// Ports:
//   clk, reset_i          clock, synchronous active-high reset
//   flush_i               drop held and output instruction (branch taken)
//   IF_ID_*/ID_IF_get_o   fetch-side handshake and payload
//   RF_rs*_addr_o/data_i  register-file read ports (same-cycle data)
//   WB_we_i, WB_rd_i      writeback commit, clears the scoreboard entry
//   ID_EX_*/EX_ID_get_i   execute-side handshake and decode bundle
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int unsigned BITSIZE = 32
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               IF_ID_give_i,
    output logic               ID_IF_get_o,
    input  logic [31:0]        IF_ID_instr_i,
    input  logic [BITSIZE-1:0] IF_ID_pc_i,
    output logic [4:0]         RF_rs1_addr_o,
    output logic [4:0]         RF_rs2_addr_o,
    input  logic [31:0]        RF_rs1_data_i,
    input  logic [31:0]        RF_rs2_data_i,
    input  logic               WB_we_i,
    input  logic [4:0]         WB_rd_i,
    output logic               ID_EX_give_o,
    input  logic               EX_ID_get_i,
    output logic [BITSIZE-1:0] ID_EX_pc_o,
    output logic [31:0]        ID_EX_op1_o,
    output logic [31:0]        ID_EX_op2_o,
    output logic [31:0]        ID_EX_imm_o,
    output logic [6:0]         ID_EX_opcode_o,
    output logic [2:0]         ID_EX_funct3_o,
    output logic               ID_EX_funct7b5_o,
    output logic [4:0]         ID_EX_rd_o,
    output logic               ID_EX_we_o,
    output logic               ID_EX_illegal_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic [1:0] {StEmpty, StDecode, StStall} state_e;

    typedef struct packed {
        logic [BITSIZE-1:0] pc;
        logic [31:0]        op1;
        logic [31:0]        op2;
        logic [31:0]        imm;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic               funct7b5;
        logic [4:0]         rd;
        logic               we;
        logic               illegal;
    } bundle_t;

    // Hold register (IF side) and output register (EX side)
    logic [31:0]        instr_q, instr_d;
    logic [BITSIZE-1:0] pc_q, pc_d;
    logic               full_q, full_d;
    bundle_t            ex_q, ex_d;
    logic               give_q, give_d;
    logic [31:0]        pending_q, pending_d;

    // Decode of the held instruction
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic        dec_legal, dec_writes, dec_we, use_rs1, use_rs2;
    logic [31:0] dec_imm;
    logic        hazard, advance, capture;
    state_e      state;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];

    always_comb begin
        dec_legal  = 1'b1;
        dec_writes = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b0;
        dec_imm    = '0;
        case (opcode)
            OpLui, OpAuipc: begin
                use_rs1 = 1'b0;
                dec_imm = {instr_q[31:12], 12'b0};
            end
            OpJal: begin
                use_rs1 = 1'b0;
                dec_imm = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            end
            OpJalr, OpLoad, OpImm: begin
                dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
            end
            OpStore: begin
                use_rs2    = 1'b1;
                dec_writes = 1'b0;
                dec_imm    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            end
            OpBranch: begin
                use_rs2    = 1'b1;
                dec_writes = 1'b0;
                dec_imm    = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            end
            OpReg: begin
                use_rs2 = 1'b1;
            end
            default: begin
                // Unknown opcodes still read rs1 for hazard purposes but never write
                dec_legal  = 1'b0;
                dec_writes = 1'b0;
            end
        endcase
    end

    assign dec_we = dec_writes & (rd != 5'd0);

    // x0 is masked here as well as never being set, so a stray bit cannot stall
    assign hazard = full_q & ((use_rs1 & (rs1 != 5'd0) & pending_q[rs1]) |
                              (use_rs2 & (rs2 != 5'd0) & pending_q[rs2]));

    // State register: the hold register itself
    always_ff @(posedge clk) begin
        if (reset_i) begin
            instr_q   <= '0;
            pc_q      <= '0;
            full_q    <= 1'b0;
            ex_q      <= '0;
            give_q    <= 1'b0;
            pending_q <= '0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            full_q    <= full_d;
            ex_q      <= ex_d;
            give_q    <= give_d;
            pending_q <= pending_d;
        end
    end

    // Output logic: decoded state and the two handshakes
    always_comb begin
        state = StEmpty;
        if (full_q) begin
            state = hazard ? StStall : StDecode;
        end
        advance     = (state == StDecode) & (!give_q | EX_ID_get_i) & !flush_i;
        ID_IF_get_o = !flush_i & (!full_q | advance);
        capture     = IF_ID_give_i & ID_IF_get_o;
    end

    // Next-state logic
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        full_d    = full_q;
        ex_d      = ex_q;
        give_d    = give_q;
        pending_d = pending_q;

        if (flush_i) begin
            full_d = 1'b0;
        end else if (capture) begin
            instr_d = IF_ID_instr_i;
            pc_d    = IF_ID_pc_i;
            full_d  = 1'b1;
        end else if (advance) begin
            full_d = 1'b0;
        end

        if (flush_i) begin
            give_d = 1'b0;
        end else if (advance) begin
            give_d      = 1'b1;
            ex_d.pc       = pc_q;
            ex_d.op1      = RF_rs1_data_i;
            ex_d.op2      = RF_rs2_data_i;
            ex_d.imm      = dec_imm;
            ex_d.opcode   = opcode;
            ex_d.funct3   = instr_q[14:12];
            ex_d.funct7b5 = instr_q[30];
            ex_d.rd       = dec_we ? rd : 5'd0;
            ex_d.we       = dec_we;
            ex_d.illegal  = !dec_legal;
        end else if (EX_ID_get_i) begin
            give_d = 1'b0;
        end

        // Clears first so that a same-cycle set on the same register wins
        if (WB_we_i) begin
            pending_d[WB_rd_i] = 1'b0;
        end
        if (flush_i && give_q && ex_q.we) begin
            pending_d[ex_q.rd] = 1'b0;
        end
        if (advance && dec_we) begin
            pending_d[rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign RF_rs1_addr_o    = rs1;
    assign RF_rs2_addr_o    = rs2;
    assign ID_EX_give_o     = give_q;
    assign ID_EX_pc_o       = ex_q.pc;
    assign ID_EX_op1_o      = ex_q.op1;
    assign ID_EX_op2_o      = ex_q.op2;
    assign ID_EX_imm_o      = ex_q.imm;
    assign ID_EX_opcode_o   = ex_q.opcode;
    assign ID_EX_funct3_o   = ex_q.funct3;
    assign ID_EX_funct7b5_o = ex_q.funct7b5;
    assign ID_EX_rd_o       = ex_q.rd;
    assign ID_EX_we_o       = ex_q.we;
    assign ID_EX_illegal_o  = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage: self-checking bench for id_stage. Table of decode vectors,
// directed multi-cycle sequences (RAW stall, backpressure, flush, scoreboard
// corner cases, reset) and a randomized run against a queue/set reference.
// -----------------------------------------------------------------------------
module tb_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        chk_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i, flush_i, if_give, id_get;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        ex_give, ex_get;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_f3;
    logic        ex_f7, ex_we, ex_ill;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'h1000_0000 + 32'(a) * 32'h0101_0101;
    endfunction

    assign rs1_data = rf_val(rs1_addr);
    assign rs2_data = rf_val(rs2_addr);

    id_stage #(.BITSIZE(32)) dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .IF_ID_give_i     (if_give),
        .ID_IF_get_o      (id_get),
        .IF_ID_instr_i    (if_instr),
        .IF_ID_pc_i       (if_pc),
        .RF_rs1_addr_o    (rs1_addr),
        .RF_rs2_addr_o    (rs2_addr),
        .RF_rs1_data_i    (rs1_data),
        .RF_rs2_data_i    (rs2_data),
        .WB_we_i          (wb_we),
        .WB_rd_i          (wb_rd),
        .ID_EX_give_o     (ex_give),
        .EX_ID_get_i      (ex_get),
        .ID_EX_pc_o       (ex_pc),
        .ID_EX_op1_o      (ex_op1),
        .ID_EX_op2_o      (ex_op2),
        .ID_EX_imm_o      (ex_imm),
        .ID_EX_opcode_o   (ex_opcode),
        .ID_EX_funct3_o   (ex_f3),
        .ID_EX_funct7b5_o (ex_f7),
        .ID_EX_rd_o       (ex_rd),
        .ID_EX_we_o       (ex_we),
        .ID_EX_illegal_o  (ex_ill)
    );

    // Sign-extend the low w bits of v arithmetically
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = 32'd1 << (w - 1);
        return (v ^ m) - m;
    endfunction

    // Reference decode straight from the RV32I instruction formats
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t    b;
        logic [6:0] op;
        logic       legal, wr;
        op       = ins[6:0];
        b        = '0;
        b.pc     = pc;
        b.op1    = rf_val(ins[19:15]);
        b.op2    = rf_val(ins[24:20]);
        b.opcode = op;
        b.f3     = ins[14:12];
        b.f7     = ins[30];
        legal    = 1'b1;
        wr       = 1'b1;
        case (op)
            7'h03, 7'h13, 7'h67: b.imm = sext(32'(ins[31:20]), 12);
            7'h23: begin
                b.imm = sext(32'({ins[31:25], ins[11:7]}), 12);
                wr    = 1'b0;
            end
            7'h63: begin
                b.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
                wr    = 1'b0;
            end
            7'h6F: b.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            7'h37, 7'h17: b.imm = ins & 32'hFFFF_F000;
            7'h33: b.imm = 32'd0;
            default: begin
                legal = 1'b0;
                wr    = 1'b0;
            end
        endcase
        b.ill = !legal;
        b.we  = wr && (ins[11:7] != 5'd0);
        b.rd  = b.we ? ins[11:7] : 5'd0;
        return b;
    endfunction

    function automatic bundle_t observe();
        bundle_t b;
        b = '{pc: ex_pc, op1: ex_op1, op2: ex_op2, imm: ex_imm, opcode: ex_opcode, f3: ex_f3,
              f7: ex_f7, rd: ex_rd, we: ex_we, ill: ex_ill};
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [10];
        ops        = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Immediate of an illegal instruction is not defined, so it is left out
    task automatic chkb(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (exp.ill) begin
            act.imm = '0;
            exp.imm = '0;
        end
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_give  = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        ex_get   = 1'b0;
        wb_we    = 1'b0;
        wb_rd    = '0;
        flush_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    localparam logic [31:0] AddiX1 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] AddX2  = 32'h0010_8133;  // add  x2,x1,x1
    localparam logic [31:0] SubX3  = 32'h4020_81B3;  // sub  x3,x1,x2
    localparam logic [31:0] LwX4   = 32'h0080_A203;  // lw   x4,8(x1)

    vec_t        vecs [10];
    bundle_t     cur, last, e, b1;
    bundle_t     exp_q [$];
    logic [31:0] iq [$];
    logic [4:0]  wbq [$];
    logic        pend [32];
    logic        give_prev, xfer_prev, wb_we_prev, raw;
    logic [4:0]  wb_rd_prev;
    logic [31:0] pc_ctr, ins;
    int          appeared;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"addi_x1_5", AddiX1,       32'h10, 1'b1, 32'h5,        5'd1, 1'b1, 1'b0};
        vecs[1] = '{"sw_m4",     32'hFE51_2E23, 32'h20, 1'b1, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0};
        vecs[2] = '{"beq_p8",    32'h0020_8463, 32'h24, 1'b1, 32'h8,        5'd0, 1'b0, 1'b0};
        vecs[3] = '{"lui",       32'h1234_52B7, 32'h28, 1'b1, 32'h1234_5000, 5'd5, 1'b1, 1'b0};
        vecs[4] = '{"jal_m2",    32'hFFFF_F0EF, 32'h2C, 1'b1, 32'hFFFF_FFFE, 5'd1, 1'b1, 1'b0};
        vecs[5] = '{"illegal",   32'h0000_00FF, 32'h30, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1};
        vecs[6] = '{"addi_x0",   32'h0010_0013, 32'h34, 1'b1, 32'h1,        5'd0, 1'b0, 1'b0};
        vecs[7] = '{"auipc",     32'hFFFF_F197, 32'h38, 1'b1, 32'hFFFF_F000, 5'd3, 1'b1, 1'b0};
        vecs[8] = '{"jalr_m1",   32'hFFF1_00E7, 32'h3C, 1'b1, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0};
        vecs[9] = '{"sub_x3",    SubX3,        32'h40, 1'b1, 32'h0,        5'd3, 1'b1, 1'b0};

        reset_i = 1'b1;
        idle();
        do_reset();

        // Reset state
        chkb("reset_bundle", observe(), '0);
        chk("reset_give", 32'(ex_give), 32'd0);
        chk("reset_get", 32'(id_get), 32'd1);
        chk("reset_rf_addr", 32'({rs1_addr, rs2_addr}), 32'd0);

        // Decode table: accept at N, offered at N+1
        for (int i = 0; i < 10; i++) begin
            do_reset();
            if_give  = 1'b1;
            if_instr = vecs[i].instr;
            if_pc    = vecs[i].pc;
            tick();
            if_give = 1'b0;
            ex_get  = 1'b1;
            tick();
            chk({vecs[i].name, "_give"}, 32'(ex_give), 32'd1);
            if (vecs[i].chk_imm) chk({vecs[i].name, "_imm"}, ex_imm, vecs[i].imm);
            chk({vecs[i].name, "_rd"}, 32'(ex_rd), 32'(vecs[i].rd));
            chk({vecs[i].name, "_we"}, 32'(ex_we), 32'(vecs[i].we));
            chk({vecs[i].name, "_ill"}, 32'(ex_ill), 32'(vecs[i].ill));
            chkb({vecs[i].name, "_bundle"}, observe(), ref_decode(vecs[i].instr, vecs[i].pc));
        end

        // RAW stall, released two edges after the writeback is presented
        do_reset();
        ex_get = 1'b1;
        if_give = 1'b1; if_instr = AddiX1; if_pc = 32'h10;
        #1 chk("raw_get_empty", 32'(id_get), 32'd1);
        tick();
        if_instr = AddX2; if_pc = 32'h14;
        #1 chk("raw_get_adv", 32'(id_get), 32'd1);
        tick();
        if_instr = 32'h0000_0013; if_pc = 32'h18;
        #1;
        chkb("raw_addi_out", observe(), ref_decode(AddiX1, 32'h10));
        chk("raw_get_stall", 32'(id_get), 32'd0);
        tick();
        chk("raw_stall1", 32'(ex_give), 32'd0);
        tick();
        chk("raw_stall2", 32'(ex_give), 32'd0);
        wb_we = 1'b1; wb_rd = 5'd1;
        tick();
        wb_we = 1'b0;
        chk("raw_no_bypass", 32'(ex_give), 32'd0);
        tick();
        chk("raw_release", 32'(ex_give), 32'd1);
        chkb("raw_add_out", observe(), ref_decode(AddX2, 32'h14));
        if_give = 1'b0;

        // Same-register set and clear in one cycle: set wins
        do_reset();
        ex_get = 1'b1;
        if_give = 1'b1; if_instr = AddiX1; if_pc = 32'h10;
        tick();
        if_instr = AddX2; if_pc = 32'h14;
        wb_we = 1'b1; wb_rd = 5'd1;
        tick();
        if_give = 1'b0; wb_we = 1'b0;
        tick();
        chk("set_wins_stall", 32'(ex_give), 32'd0);
        wb_we = 1'b1; wb_rd = 5'd1;
        tick();
        wb_we = 1'b0;
        tick();
        chk("set_wins_release", 32'(ex_rd), 32'd2);

        // EX backpressure for three cycles
        do_reset();
        if_give = 1'b1; if_instr = 32'h0010_0293; if_pc = 32'h100;
        tick();
        if_instr = 32'h0020_0313; if_pc = 32'h104;
        #1 chk("bp_get_first", 32'(id_get), 32'd1);
        tick();
        if_instr = 32'h0030_0393; if_pc = 32'h108;
        b1 = ref_decode(32'h0010_0293, 32'h100);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_give", 32'(ex_give), 32'd1);
            chk("bp_get_blocked", 32'(id_get), 32'd0);
            chkb("bp_stable", observe(), b1);
            tick();
        end
        chkb("bp_stable_end", observe(), b1);
        ex_get = 1'b1;
        #1 chk("bp_release_get", 32'(id_get), 32'd1);
        tick();
        if_give = 1'b0;
        chkb("bp_second", observe(), ref_decode(32'h0020_0313, 32'h104));
        tick();
        chkb("bp_third", observe(), ref_decode(32'h0030_0393, 32'h108));
        tick();
        chk("bp_drain", 32'(ex_give), 32'd0);

        // Flush with SUB x3 in output and LW x4 held
        do_reset();
        if_give = 1'b1; if_instr = SubX3; if_pc = 32'h200;
        tick();
        if_instr = LwX4; if_pc = 32'h204;
        tick();
        chk("flush_pre_rd", 32'(ex_rd), 32'd3);
        flush_i = 1'b1; if_instr = 32'h0010_0493; if_pc = 32'h208;
        #1 chk("flush_get", 32'(id_get), 32'd0);
        tick();
        flush_i = 1'b0; if_give = 1'b0;
        chk("flush_out", 32'(ex_give), 32'd0);
        tick();
        chk("flush_hold", 32'(ex_give), 32'd0);
        ex_get = 1'b1; if_give = 1'b1; if_instr = 32'h0031_82B3; if_pc = 32'h20C;
        tick();
        if_give = 1'b0;
        tick();
        chk("flush_pend3_give", 32'(ex_give), 32'd1);
        chk("flush_pend3_rd", 32'(ex_rd), 32'd5);

        // x0 and illegal destinations never mark the scoreboard
        do_reset();
        ex_get = 1'b1;
        if_give = 1'b1; if_instr = 32'h0010_0013; if_pc = 32'h300;
        tick();
        if_instr = 32'h0000_02B3; if_pc = 32'h304;
        tick();
        chkb("x0_addi", observe(), ref_decode(32'h0010_0013, 32'h300));
        if_instr = 32'h0000_00FF; if_pc = 32'h308;
        tick();
        chkb("x0_no_stall", observe(), ref_decode(32'h0000_02B3, 32'h304));
        if_instr = 32'h0010_8333; if_pc = 32'h30C;
        tick();
        chk("ill_flag", 32'(ex_ill), 32'd1);
        if_give = 1'b0;
        tick();
        chkb("ill_no_pending", observe(), ref_decode(32'h0010_8333, 32'h30C));

        // Reset in the middle of traffic
        do_reset();
        if_give = 1'b1; if_instr = AddiX1; if_pc = 32'h10;
        tick();
        if_instr = AddX2; if_pc = 32'h14;
        tick();
        reset_i = 1'b1; ex_get = 1'b1;
        tick();
        reset_i = 1'b0; if_give = 1'b0;
        chkb("reset_mid_bundle", observe(), '0);
        chk("reset_mid_give", 32'(ex_give), 32'd0);
        #1 chk("reset_mid_get", 32'(id_get), 32'd1);

        // Randomized traffic against an ordered queue and a pending-register set
        do_reset();
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        give_prev  = 1'b0;
        xfer_prev  = 1'b0;
        wb_we_prev = 1'b0;
        wb_rd_prev = '0;
        pc_ctr     = 32'h1000;
        appeared   = 0;
        last       = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (xfer_prev && last.we) wbq.push_back(last.rd);
            cur = observe();
            raw = 1'b0;
            if (ex_give && (!give_prev || xfer_prev)) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious", 32'(ex_give), 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    ins = iq.pop_front();
                    appeared++;
                    chkb("rand_bundle", cur, e);
                    raw = ((ins[6:0] != 7'h37 && ins[6:0] != 7'h17 && ins[6:0] != 7'h6F)
                           && ins[19:15] != 5'd0 && pend[ins[19:15]])
                       || ((ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63)
                           && ins[24:20] != 5'd0 && pend[ins[24:20]]);
                    chk("rand_raw", 32'(raw), 32'd0);
                    if (wb_we_prev) pend[wb_rd_prev] = 1'b0;
                    if (e.we) pend[e.rd] = 1'b1;
                end
            end else begin
                if (ex_give && give_prev) chkb("rand_stable", cur, last);
                if (wb_we_prev) pend[wb_rd_prev] = 1'b0;
            end
            last      = cur;
            give_prev = ex_give;

            if_give  = (cyc < 2500) && ($urandom_range(0, 3) != 0);
            if_instr = rand_instr();
            if_pc    = pc_ctr;
            ex_get   = ($urandom_range(0, 3) != 0);
            if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb_we = 1'b1;
                wb_rd = wbq.pop_front();
            end else begin
                wb_we = 1'b0;
            end
            #1;
            if (if_give && id_get) begin
                exp_q.push_back(ref_decode(if_instr, if_pc));
                iq.push_back(if_instr);
                pc_ctr += 32'd4;
            end
            xfer_prev  = ex_give && ex_get;
            wb_we_prev = wb_we;
            wb_rd_prev = wb_rd;
        end
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("rand_progress", 32'(appeared > 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
